// File: rtl/key_pulse_debouncer_if.sv
// -----------------------------------------------------------------------------
// key_pulse_debouncer_if
//   Groups the key-side signals of the push-button debouncer.
//
//   KeyN  : raw push-button, active-low (0 = pressed), asynchronous
//   Pulse : single-cycle, active-high count strobe
//   Level : debounced key state, 1 = pressed
//
//   master : the side that owns the button and consumes the strobe/level
//   slave  : the debouncer itself
// -----------------------------------------------------------------------------
interface key_pulse_debouncer_if;
   logic KeyN;
   logic Pulse;
   logic Level;

   modport master (output KeyN, input Pulse, input Level);
   modport slave  (input KeyN, output Pulse, output Level);
endinterface

// File: rtl/key_pulse_debouncer.sv
// -----------------------------------------------------------------------------
// key_pulse_debouncer
//   Conditions a raw, bouncy, active-low push-button so that the downstream
//   BCD counter advances exactly once per physical press, and provides a
//   debounced level for the green LED.
//
//   Ports:
//     CLOCK_50 : board clock, all state updates on its rising edge
//     Reset    : synchronous, active-high reset
//     bus      : key_pulse_debouncer_if.slave (KeyN in, Pulse/Level out)
//
//   Parameters:
//     STABLE_CYCLES : clocks the synchronised key must hold a new level
//                     before it is accepted (>= 2)
//     REPEAT_DELAY  : clocks in PRESSED before the first auto-repeat pulse
//     REPEAT_PERIOD : clocks between later auto-repeat pulses (>= 2)
//
//   Optional feature, macro KEY_AUTOREPEAT_EN:
//     When defined, holding the key emits extra pulses, the first one
//     REPEAT_DELAY clocks after entering PRESSED and then one every
//     REPEAT_PERIOD clocks. The REPEAT_* parameters exist only in that build.
//     When undefined, exactly one pulse is produced per accepted press.
// -----------------------------------------------------------------------------
module key_pulse_debouncer #(
   parameter int STABLE_CYCLES = 1000000
`ifdef KEY_AUTOREPEAT_EN
   ,
   parameter int REPEAT_DELAY  = 25000000,
   parameter int REPEAT_PERIOD = 5000000
`endif
) (
   input logic                  CLOCK_50,
   input logic                  Reset,
   key_pulse_debouncer_if.slave bus
);

   localparam int CW = $clog2(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

`ifdef KEY_AUTOREPEAT_EN
   localparam int REPEAT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW = $clog2(REPEAT_MAX);
   localparam logic [RW-1:0] DELAY_MAX  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PERIOD_MAX = RW'(REPEAT_PERIOD - 1);
`endif

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            pulse_q;
   logic            level_q;
   logic            sync_1;
   logic            sync_2;
   logic            pressed;

`ifdef KEY_AUTOREPEAT_EN
   logic [RW-1:0]   rep_cnt;
   logic            rep_phase;   // 0: waiting REPEAT_DELAY, 1: repeating every REPEAT_PERIOD
`endif

   // Two-flop synchroniser; reset value 1 means "released".
   // NOTE: sequential state always uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours, which is what makes this a
   // two-stage shift and not a single wire.
   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         sync_1 <= 1'b1;
         sync_2 <= 1'b1;
      end else begin
         sync_1 <= bus.KeyN;
         sync_2 <= sync_1;
      end
   end

   assign pressed = ~sync_2;

   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         state   <= IDLE;
         cnt     <= '0;
         pulse_q <= 1'b0;
         level_q <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
         rep_cnt   <= '0;
         rep_phase <= 1'b0;
`endif
      end else begin
         // NOTE: the strobe defaults low every cycle and is raised only on the
         // cycles that earn it, so it can never stick high.
         pulse_q <= 1'b0;

         case (state)
            IDLE: begin
               if (pressed) begin
                  state <= PRESS_WAIT;
                  cnt   <= '0;
               end
            end

            PRESS_WAIT: begin
               if (!pressed) begin
                  state <= IDLE;          // bounce: discard, no pulse
                  cnt   <= '0;
               end else if (cnt == CNT_MAX) begin
                  state   <= PRESSED;
                  cnt     <= '0;
                  pulse_q <= 1'b1;
                  level_q <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            PRESSED: begin
               if (!pressed) begin
                  state <= RELEASE_WAIT;
                  cnt   <= '0;
`ifdef KEY_AUTOREPEAT_EN
                  // Leaving PRESSED always rewinds to the delay phase, so a
                  // glitch back into PRESSED restarts REPEAT_DELAY.
                  rep_cnt   <= '0;
                  rep_phase <= 1'b0;
               end else if (rep_cnt == (rep_phase ? PERIOD_MAX : DELAY_MAX)) begin
                  pulse_q   <= 1'b1;
                  rep_cnt   <= '0;
                  rep_phase <= 1'b1;
               end else begin
                  rep_cnt <= rep_cnt + 1'b1;
`endif
               end
            end

            RELEASE_WAIT: begin
               if (pressed) begin
                  state <= PRESSED;       // release glitch: no new pulse
                  cnt   <= '0;
               end else if (cnt == CNT_MAX) begin
                  state   <= IDLE;
                  cnt     <= '0;
                  level_q <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign bus.Pulse = pulse_q;
   assign bus.Level = level_q;

endmodule

// File: tb/tb_key_pulse_debouncer.sv
// -----------------------------------------------------------------------------
// tb_key_pulse_debouncer
//   Directed bench for key_pulse_debouncer with STABLE_CYCLES = 4 (and, when
//   KEY_AUTOREPEAT_EN is defined, REPEAT_DELAY = 10, REPEAT_PERIOD = 3).
//   Edge numbering: edge 0 is the first rising edge that samples a new KeyN.
//   Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_key_pulse_debouncer;

   localparam int STABLE_CYCLES = 4;
   localparam int ACCEPT_EDGE   = STABLE_CYCLES + 2;   // edge after which Pulse/Level change
`ifdef KEY_AUTOREPEAT_EN
   localparam int  REPEAT_DELAY  = 10;
   localparam int  REPEAT_PERIOD = 3;
   localparam bit  AUTOREPEAT    = 1'b1;
`else
   localparam int  REPEAT_DELAY  = 0;
   localparam int  REPEAT_PERIOD = 1;
   localparam bit  AUTOREPEAT    = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks    = 0;
   int   fails     = 0;
   int   pulse_cnt = 0;

   key_pulse_debouncer_if bus ();

   key_pulse_debouncer #(
      .STABLE_CYCLES(STABLE_CYCLES)
`ifdef KEY_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
   ) dut (
      .CLOCK_50(clk),
      .Reset   (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // One rising edge, then settle; counts strobes seen.
   task automatic tick();
      @(posedge clk);
      #1;
      if (bus.Pulse === 1'b1) pulse_cnt++;
   endtask

   task automatic idle(input int n);
      bus.KeyN = 1'b1;
      repeat (n) tick();
   endtask

   // Expected strobe k edges after entering PRESSED while still held.
   function automatic bit model_pulse(input int k);
      if (k == 0) return 1'b1;
      if (AUTOREPEAT && k >= REPEAT_DELAY && ((k - REPEAT_DELAY) % REPEAT_PERIOD) == 0)
         return 1'b1;
      return 1'b0;
   endfunction

   task automatic test_reset();
      bit exp_p, exp_l;
      rst = 1'b1;
      bus.KeyN = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (bus.Pulse !== 1'b0 || bus.Level !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold[%0d]: Pulse=%b Level=%b, required 0 0", i, bus.Pulse, bus.Level);
         end
      end
      rst = 1'b0;
      pulse_cnt = 0;
      for (int e = 0; e <= ACCEPT_EDGE + 1; e++) begin
         tick();
         exp_p = (e == ACCEPT_EDGE);
         exp_l = (e >= ACCEPT_EDGE);
         checks++;
         if (bus.Pulse !== exp_p || bus.Level !== exp_l) begin
            fails++;
            $display("FAIL reset_release edge %0d: Pulse=%b Level=%b, required %b %b",
                     e, bus.Pulse, bus.Level, exp_p, exp_l);
         end
      end
      bus.KeyN = 1'b1;
      for (int e = 0; e <= ACCEPT_EDGE; e++) begin
         tick();
         exp_l = (e < ACCEPT_EDGE);
         checks++;
         if (bus.Level !== exp_l) begin
            fails++;
            $display("FAIL reset_key_up edge %0d: Level=%b, required %b", e, bus.Level, exp_l);
         end
      end
   endtask

   task automatic test_clean_press();
      bit exp_p, exp_l;
      int exp_cnt = 0;
      idle(4);
      pulse_cnt = 0;
      bus.KeyN = 1'b0;
      for (int e = 0; e < 20; e++) begin
         tick();
         exp_p = (e >= ACCEPT_EDGE) ? model_pulse(e - ACCEPT_EDGE) : 1'b0;
         exp_l = (e >= ACCEPT_EDGE);
         if (exp_p) exp_cnt++;
         checks++;
         if (bus.Pulse !== exp_p || bus.Level !== exp_l) begin
            fails++;
            $display("FAIL clean_press edge %0d: Pulse=%b Level=%b, required %b %b",
                     e, bus.Pulse, bus.Level, exp_p, exp_l);
         end
      end
      bus.KeyN = 1'b1;
      for (int e = 0; e < ACCEPT_EDGE + 2; e++) begin
         tick();
         exp_l = (e < ACCEPT_EDGE);
         checks++;
         if (bus.Pulse !== 1'b0 || bus.Level !== exp_l) begin
            fails++;
            $display("FAIL clean_release edge %0d: Pulse=%b Level=%b, required 0 %b",
                     e, bus.Pulse, bus.Level, exp_l);
         end
      end
      checks++;
      if (pulse_cnt !== exp_cnt) begin
         fails++;
         $display("FAIL clean_pulse_count: got %0d, required %0d", pulse_cnt, exp_cnt);
      end
   endtask

   task automatic test_bounce_press();
      bit exp_p, exp_l;
      logic bounce [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      idle(4);
      pulse_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         bus.KeyN = bounce[i];
         tick();
      end
      checks++;
      if (pulse_cnt !== 0 || bus.Level !== 1'b0) begin
         fails++;
         $display("FAIL bounce_during: pulses=%0d Level=%b, required 0 0", pulse_cnt, bus.Level);
      end
      bus.KeyN = 1'b0;
      for (int e = 0; e < ACCEPT_EDGE + 4; e++) begin
         tick();
         exp_p = (e == ACCEPT_EDGE);
         exp_l = (e >= ACCEPT_EDGE);
         checks++;
         if (bus.Pulse !== exp_p || bus.Level !== exp_l) begin
            fails++;
            $display("FAIL bounce_press edge %0d: Pulse=%b Level=%b, required %b %b",
                     e, bus.Pulse, bus.Level, exp_p, exp_l);
         end
      end
      checks++;
      if (pulse_cnt !== 1) begin
         fails++;
         $display("FAIL bounce_pulse_count: got %0d, required 1", pulse_cnt);
      end
      idle(ACCEPT_EDGE + 2);
   endtask

   task automatic test_bounce_release();
      bit exp_l;
      idle(4);
      bus.KeyN = 1'b0;
      repeat (ACCEPT_EDGE + 2) tick();
      pulse_cnt = 0;
      for (int i = 0; i < 7; i++) begin
         bus.KeyN = (i < 2) ? 1'b1 : 1'b0;
         tick();
         checks++;
         if (bus.Level !== 1'b1) begin
            fails++;
            $display("FAIL release_glitch step %0d: Level=%b, required 1", i, bus.Level);
         end
      end
      bus.KeyN = 1'b1;
      for (int e = 0; e < ACCEPT_EDGE + 2; e++) begin
         tick();
         exp_l = (e < ACCEPT_EDGE);
         checks++;
         if (bus.Level !== exp_l) begin
            fails++;
            $display("FAIL release_final edge %0d: Level=%b, required %b", e, bus.Level, exp_l);
         end
      end
      checks++;
      if (pulse_cnt !== 0) begin
         fails++;
         $display("FAIL release_extra_pulses: got %0d, required 0", pulse_cnt);
      end
   endtask

   task automatic test_reset_mid_press();
      bit exp_p, exp_l;
      idle(4);
      pulse_cnt = 0;
      bus.KeyN = 1'b0;
      for (int e = 0; e < 4; e++) tick();
      rst = 1'b1;
      tick();   // edge 4 samples Reset
      checks++;
      if (pulse_cnt !== 0 || bus.Pulse !== 1'b0 || bus.Level !== 1'b0) begin
         fails++;
         $display("FAIL midreset_edge4: pulses=%0d Pulse=%b Level=%b, required 0 0 0",
                  pulse_cnt, bus.Pulse, bus.Level);
      end
      rst = 1'b0;
      for (int e = 0; e < ACCEPT_EDGE + 3; e++) begin
         tick();
         exp_p = (e == ACCEPT_EDGE);
         exp_l = (e >= ACCEPT_EDGE);
         checks++;
         if (bus.Pulse !== exp_p || bus.Level !== exp_l) begin
            fails++;
            $display("FAIL midreset_requalify edge %0d: Pulse=%b Level=%b, required %b %b",
                     e, bus.Pulse, bus.Level, exp_p, exp_l);
         end
      end
      checks++;
      if (pulse_cnt !== 1) begin
         fails++;
         $display("FAIL midreset_pulse_count: got %0d, required 1", pulse_cnt);
      end
      idle(ACCEPT_EDGE + 2);
   endtask

`ifdef KEY_AUTOREPEAT_EN
   task automatic test_autorepeat();
      bit exp_p, exp_l;
      localparam int REL_EDGE = ACCEPT_EDGE + 29;   // first edge sampling KeyN = 1
      idle(4);
      pulse_cnt = 0;
      bus.KeyN = 1'b0;
      for (int e = 0; e < REL_EDGE + ACCEPT_EDGE + 4; e++) begin
         if (e == REL_EDGE) bus.KeyN = 1'b1;
         tick();
         // PRESSED is left two edges after the release is sampled.
         exp_p = (e >= ACCEPT_EDGE && e < REL_EDGE + 2) ? model_pulse(e - ACCEPT_EDGE) : 1'b0;
         exp_l = (e >= ACCEPT_EDGE && e < REL_EDGE + ACCEPT_EDGE);
         checks++;
         if (bus.Pulse !== exp_p || bus.Level !== exp_l) begin
            fails++;
            $display("FAIL autorepeat edge %0d: Pulse=%b Level=%b, required %b %b",
                     e, bus.Pulse, bus.Level, exp_p, exp_l);
         end
      end
      checks++;
      if (pulse_cnt !== 8) begin
         fails++;
         $display("FAIL autorepeat_pulse_count: got %0d, required 8", pulse_cnt);
      end
   endtask
`endif

   initial begin
      bus.KeyN = 1'b1;
      test_reset();
      test_clean_press();
      test_bounce_press();
      test_bounce_release();
      test_reset_mid_press();
`ifdef KEY_AUTOREPEAT_EN
      test_autorepeat();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
